// File: rtl/irq_source_pkg.sv
// Shared types and sizes for the interrupt request generator.
// Defines the per-channel handshake state encoding and the served-request adder.
package irq_source_pkg;

   localparam int IRQ_CHANNELS = 3;
   localparam int SERVED_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_REQ   = 2'b01,
      ST_SERVE = 2'b10
   } irq_state_t;

   // Number of channels accepted by the CPU in one cycle, widened for the counter.
   function automatic logic [SERVED_W-1:0] served_inc(input logic [IRQ_CHANNELS-1:0] v);
      served_inc = '0;
      for (int i = 0; i < IRQ_CHANNELS; i++) begin
         served_inc = served_inc + SERVED_W'(v[i]);
      end
   endfunction

endpackage

// File: rtl/irq_debounce.sv
// One button channel: 2-flop synchronizer, optional debouncer (IRQ_SOURCE_DEBOUNCE_EN), press pulse.
// o_press is a one-cycle pulse on an accepted 0->1 level change; releases produce nothing.
module irq_debounce #(
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic i_clk,
   input  logic i_clr,
   input  logic i_btn,
   output logic o_press
);

   logic r_s0;
   logic r_s1;
   logic r_stable;

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce_cycles
      $error("irq_debounce: DEBOUNCE_CYCLES out of range 1..65535");
   end

`ifdef IRQ_SOURCE_DEBOUNCE_EN
   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [15:0] r_cnt;
   logic        r_stable_d;

   // A level is accepted once s1 has disagreed with stable for DEBOUNCE_CYCLES cycles in a row.
   always_ff @(posedge i_clk) begin
      if (!i_clr) begin
         r_s0       <= 1'b0;
         r_s1       <= 1'b0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_s0       <= i_btn;
         r_s1       <= r_s0;
         r_stable_d <= r_stable;
         if (r_s1 != r_stable) begin
            if (r_cnt == CNT_LAST) begin
               r_stable <= r_s1;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 16'd1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_press = r_stable & ~r_stable_d;
`else
   always_ff @(posedge i_clk) begin
      if (!i_clr) begin
         r_s0     <= 1'b0;
         r_s1     <= 1'b0;
         r_stable <= 1'b0;
      end else begin
         r_s0     <= i_btn;
         r_s1     <= r_s0;
         r_stable <= r_s1;
      end
   end

   // Without filtering the edge is taken straight off s1 so the FSM sees it one cycle sooner.
   assign o_press = r_s1 & ~r_stable;
`endif

endmodule

// File: rtl/irq_source.sv
// Turns button presses into held CPU interrupt requests with a one-deep queue per channel.
// Debouncing is enabled by defining IRQ_SOURCE_DEBOUNCE_EN; otherwise every synchronized rise is a press.
module irq_source
   import irq_source_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [IRQ_CHANNELS-1:0] btn,
   input  logic [IRQ_CHANNELS-1:0] running,
   output logic [IRQ_CHANNELS-1:0] irq,
   output logic [IRQ_CHANNELS-1:0] pending,
   output logic [IRQ_CHANNELS-1:0] dropped,
   output logic [SERVED_W-1:0]     served_count
);

   logic [IRQ_CHANNELS-1:0] w_press;
   irq_state_t              r_state     [IRQ_CHANNELS];
   irq_state_t              w_state_nxt [IRQ_CHANNELS];

   logic [IRQ_CHANNELS-1:0] w_irq_nxt;
   logic [IRQ_CHANNELS-1:0] w_pend_nxt;
   logic [IRQ_CHANNELS-1:0] w_drop_nxt;
   logic [IRQ_CHANNELS-1:0] w_serve;

   logic [IRQ_CHANNELS-1:0] r_irq;
   logic [IRQ_CHANNELS-1:0] r_pending;
   logic [IRQ_CHANNELS-1:0] r_dropped;
   logic [SERVED_W-1:0]     r_served_count;

   for (genvar g = 0; g < IRQ_CHANNELS; g++) begin : g_chan
      irq_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .i_clk   (clk),
         .i_clr   (clr),
         .i_btn   (btn[g]),
         .o_press (w_press[g])
      );
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < IRQ_CHANNELS; c++) begin
         if (!clr) begin
            r_state[c] <= ST_IDLE;
         end else begin
            r_state[c] <= w_state_nxt[c];
         end
      end
   end

   always_comb begin
      for (int c = 0; c < IRQ_CHANNELS; c++) begin
         w_state_nxt[c] = r_state[c];
         case (r_state[c])
            ST_IDLE:  if (w_press[c] || r_pending[c]) w_state_nxt[c] = ST_REQ;
            ST_REQ:   if (running[c])                 w_state_nxt[c] = ST_SERVE;
            ST_SERVE: if (!running[c])                w_state_nxt[c] = ST_IDLE;
            default:                                  w_state_nxt[c] = ST_IDLE;
         endcase
      end
   end

   // Leaving IDLE consumes the queued request; a press landing on that same cycle takes its place.
   always_comb begin
      w_irq_nxt  = '0;
      w_pend_nxt = r_pending;
      w_drop_nxt = r_dropped;
      w_serve    = '0;
      for (int c = 0; c < IRQ_CHANNELS; c++) begin
         w_irq_nxt[c] = (w_state_nxt[c] == ST_REQ);
         w_serve[c]   = (r_state[c] == ST_REQ) && running[c];
         if (r_state[c] == ST_IDLE) begin
            w_pend_nxt[c] = w_press[c] & r_pending[c];
         end else if (w_press[c]) begin
            if (r_pending[c]) begin
               w_drop_nxt[c] = 1'b1;
            end else begin
               w_pend_nxt[c] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_irq          <= '0;
         r_pending      <= '0;
         r_dropped      <= '0;
         r_served_count <= '0;
      end else begin
         r_irq          <= w_irq_nxt;
         r_pending      <= w_pend_nxt;
         r_dropped      <= w_drop_nxt;
         r_served_count <= r_served_count + served_inc(w_serve);
      end
   end

   assign irq          = r_irq;
   assign pending      = r_pending;
   assign dropped      = r_dropped;
   assign served_count = r_served_count;

endmodule

// File: tb/tb_irq_source.sv
// Bench for irq_source: directed handshake/queue/wrap scenarios plus randomized buttons and CPU replies,
// all compared every cycle against a behavioural model of the request protocol.
module tb_irq_source;

   localparam int D = 4;
`ifdef IRQ_SOURCE_DEBOUNCE_EN
   localparam int LAT  = D + 3;
   localparam int HOLD = D + 3;
`else
   localparam int LAT  = 3;
   localparam int HOLD = 3;
`endif

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [2:0]  btn = 3'b000;
   logic [2:0]  running = 3'b000;
   logic [2:0]  irq;
   logic [2:0]  pending;
   logic [2:0]  dropped;
   logic [15:0] served_count;

   irq_source #(
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk          (clk),
      .clr          (clr),
      .btn          (btn),
      .running      (running),
      .irq          (irq),
      .pending      (pending),
      .dropped      (dropped),
      .served_count (served_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: per channel, btn sample history, accepted level, phase 0=idle 1=requesting 2=in service.
   bit [3:0]    m_hist [3];
   bit          m_lvl  [3];
   int          m_run  [3];
   bit          m_rose [3];
   int          m_ph   [3];
   bit          m_pend [3];
   bit          m_drop [3];
   logic [15:0] m_cnt;

   always @(posedge clk) begin
      if (!clr) begin
         for (int c = 0; c < 3; c++) begin
            m_hist[c] = '0; m_lvl[c] = 1'b0; m_run[c] = 0; m_rose[c] = 1'b0;
            m_ph[c] = 0; m_pend[c] = 1'b0; m_drop[c] = 1'b0;
         end
         m_cnt = '0;
      end else begin
         for (int c = 0; c < 3; c++) begin
            bit press;
            bit seen;
            m_hist[c] = {m_hist[c][2:0], btn[c]};
            seen = m_hist[c][2];
`ifdef IRQ_SOURCE_DEBOUNCE_EN
            press = m_rose[c];
            m_rose[c] = 1'b0;
            if (seen != m_lvl[c]) begin
               m_run[c]++;
               if (m_run[c] == D) begin
                  m_rose[c] = seen;
                  m_lvl[c]  = seen;
                  m_run[c]  = 0;
               end
            end else begin
               m_run[c] = 0;
            end
`else
            press = seen & ~m_hist[c][3];
`endif
            case (m_ph[c])
               0: begin
                  if (press || m_pend[c]) m_ph[c] = 1;
                  m_pend[c] = press & m_pend[c];
               end
               default: begin
                  if (m_ph[c] == 1 && running[c]) begin
                     m_ph[c] = 2;
                     m_cnt   = m_cnt + 16'd1;
                  end else if (m_ph[c] == 2 && !running[c]) begin
                     m_ph[c] = 0;
                  end
                  if (press) begin
                     if (m_pend[c]) m_drop[c] = 1'b1;
                     else           m_pend[c] = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_irq",     int'(irq),     int'({m_ph[2] == 1, m_ph[1] == 1, m_ph[0] == 1}));
         check("model_pending", int'(pending), int'({m_pend[2], m_pend[1], m_pend[0]}));
         check("model_dropped", int'(dropped), int'({m_drop[2], m_drop[1], m_drop[0]}));
         check("model_served",  int'(served_count), int'(m_cnt));
      end
   end

   task automatic press(input logic [2:0] mask);
      btn = btn | mask;
      repeat (HOLD) @(negedge clk);
      btn = btn & ~mask;
      repeat (HOLD) @(negedge clk);
   endtask

   task automatic wait_irq(input logic [2:0] mask, input string name);
      int k = 0;
      while ((irq & mask) != mask && k < 60) begin
         @(negedge clk);
         k++;
      end
      check(name, int'((irq & mask) == mask), 1);
   endtask

   int          edges;
   bit          saw;
   logic [15:0] exp_served;

   initial begin
      clr = 1'b0;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("reset_irq", int'(irq), 0);
      check("reset_pending", int'(pending), 0);
      check("reset_dropped", int'(dropped), 0);
      check("reset_served", int'(served_count), 0);
      clr = 1'b1;
      repeat (2) @(negedge clk);

`ifdef IRQ_SOURCE_DEBOUNCE_EN
      btn[0] = 1'b1;
      repeat (3) @(negedge clk);
      btn[0] = 1'b0;
      saw = 1'b0;
      repeat (D + 8) begin
         @(negedge clk);
         if (irq[0]) saw = 1'b1;
      end
      check("glitch_no_irq", int'(saw), 0);
`endif

      btn[0] = 1'b1;
      edges = 0;
      do begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end while (!irq[0] && edges < 50);
      check("latency_edges", edges, LAT);

      running[0] = 1'b1;
      @(negedge clk);
      exp_served = 16'd1;
      check("serve0_irq_low", int'(irq[0]), 0);
      check("serve0_count", int'(served_count), int'(exp_served));
      running[0] = 1'b0;
      btn[0] = 1'b0;
      repeat (HOLD) @(negedge clk);

      press(3'b010);
      wait_irq(3'b010, "ch1_irq");
      running[1] = 1'b1;
      @(negedge clk);
      exp_served++;
      check("serve1_irq_low", int'(irq[1]), 0);
      check("serve1_count", int'(served_count), int'(exp_served));
      running[1] = 1'b0;
      repeat (3) @(negedge clk);
      check("serve1_back_idle", int'(irq[1]), 0);

      press(3'b100);
      wait_irq(3'b100, "ch2_irq");
      running[2] = 1'b1;
      @(negedge clk);
      exp_served++;
      press(3'b100);
      check("queue_pending", int'(pending[2]), 1);
      check("queue_not_dropped", int'(dropped[2]), 0);
      press(3'b100);
      check("queue_dropped", int'(dropped[2]), 1);
      running[2] = 1'b0;
      @(negedge clk);
      check("queue_idle_gap", int'(irq[2]), 0);
      @(negedge clk);
      check("queue_reissue_irq", int'(irq[2]), 1);
      check("queue_pending_clear", int'(pending[2]), 0);
      running[2] = 1'b1;
      @(negedge clk);
      exp_served++;
      running[2] = 1'b0;
      repeat (2) @(negedge clk);

      press(3'b111);
      wait_irq(3'b111, "all_irq");
      running = 3'b111;
      @(negedge clk);
      exp_served = exp_served + 16'd3;
      check("all_count", int'(served_count), int'(exp_served));
      running = 3'b000;
      repeat (2) @(negedge clk);

      #2;
      force dut.r_served_count = 16'hFFFE;
      m_cnt = 16'hFFFE;
      #1;
      release dut.r_served_count;
      press(3'b111);
      wait_irq(3'b111, "wrap_irq");
      running = 3'b111;
      @(negedge clk);
      check("wrap_count", int'(served_count), 16'h0001);
      running = 3'b000;
      repeat (2) @(negedge clk);

      btn[0] = 1'b1;
      wait_irq(3'b001, "rst_irq_before");
      clr = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      btn[0] = 1'b0;
      check("midrst_irq", int'(irq), 0);
      check("midrst_served", int'(served_count), 0);
      check("midrst_dropped", int'(dropped), 0);
      @(negedge clk);
      check("midrst_idle", int'(irq), 0);

      repeat (3000) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            if ($urandom_range(0, 5) == 0) btn[c] = ~btn[c];
            if ($urandom_range(0, 3) == 0) running[c] = ~running[c];
         end
         clr = ($urandom_range(0, 699) != 0);
      end
      clr = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/irq_source.md
# irq_source

Interrupt request generator driving the CPU's three external interrupt lines, the requesting end of the CPU's `inter1..3` / `inter_running1..3` handshake. It synchronizes and debounces three push-button inputs and turns each press into a held request. The request stays up until the CPU signals it is servicing that line, and the block tracks completion. It sits in the top level between board buttons and `MIPS_CPU`, clocked by the CPU clock (`clk_N`).

## Interface
- `DEBOUNCE_CYCLES`, default 20: consecutive stable cycles required to accept a button level change; legal range 1..65535.
- `clk`  input  1  CPU clock; connect to `clk_N`; all logic on rising edge.
- `clr`  input  1  reset, synchronous, active-low.
- `btn`  input  3  raw asynchronous push buttons; bit i is channel i.
- `running`  input  3  CPU in-service flags (`inter_running1..3`), bit i is channel i.
- `irq`  output  3  interrupt requests to CPU (`inter1..3`), registered.
- `pending`  output  3  a second press is queued behind the active one, registered.
- `dropped`  output  3  sticky: a press was lost because the queue was full, registered.
- `served_count`  output  16  total requests accepted by the CPU across all channels, registered.

## Operation
- Per channel, input path: 2-flop synchronizer (`s0`, `s1`), then debouncer with a 16-bit counter and `stable` register.
  - Each cycle `s1 != stable`: increment the counter. When the counter reaches `DEBOUNCE_CYCLES-1`, load `stable <= s1` and clear the counter.
  - Any cycle `s1 == stable`: clear the counter.
- A press event is a `stable` 0→1 transition. Releases generate nothing.
- Per-channel FSM:
  - IDLE: `irq=0`. On a press event, or with `pending=1`, go to REQ and clear `pending`.
  - REQ: `irq=1`. On `running=1`, go to SERVE and increment `served_count` (wraps 0xFFFF→0).
  - SERVE: `irq=0`. On `running=0`, go to IDLE.
- A press in REQ or SERVE sets `pending` if it is clear. If `pending` is already set, set `dropped` instead.
- A press in the same cycle as SERVE→IDLE sets `pending`. The channel re-enters REQ the following cycle.
- `running=1` while in IDLE is ignored; the channel stays in IDLE.
- Channels are independent; all three may request simultaneously.
- Several channels entering SERVE in the same cycle each count, so `served_count` adds 0..3 in one cycle.
- Reset, including mid-handshake, forces:
  - all FSMs to IDLE
  - `irq=0`, `pending=0`, `dropped=0`, `served_count=0`
  - synchronizers, `stable`, and counters to 0.

## Timing
- All outputs are registered. Reset values are all zero.
- With the debouncer, `btn` rise to `irq` rise takes `DEBOUNCE_CYCLES+3` edges, counting from the edge that first samples `btn=1`:
  - edge 1 captures `s0`; edge 2 captures `s1`
  - edges 3..D+2 count, with `stable` set at edge D+2
  - `irq` rises at edge D+3.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no event.
- `irq` falls on the edge after the first sampled `running=1`.
- From SERVE, IDLE is entered on the edge after the first sampled `running=0`. A queued request raises `irq` one edge later.
- Minimum spacing between two requests on one channel: 3 cycles (REQ, SERVE, IDLE).

## Configuration
- `IRQ_SOURCE_DEBOUNCE_EN` defined: debouncer as described; `DEBOUNCE_CYCLES` applies.
- Not defined: `stable <= s1` every cycle and the counter is removed. Latency becomes 3 edges. Every synchronized rising edge is a press.

## Structure
- Package `irq_source_pkg`:
  - state encoding IDLE=2'b00, REQ=2'b01, SERVE=2'b10
  - `IRQ_CHANNELS = 3`
  - `SERVED_W = 16`
- Sub-module `irq_debounce`: one channel's synchronizer, debouncer and press-event output. Instantiated `IRQ_CHANNELS` times.
- FSMs, `pending`/`dropped` logic and `served_count` live in the top of the block.

## Test plan
- Reset mid-operation: channel 0 in REQ, assert `clr=0` for 1 cycle → next cycle `irq=0`, `served_count=0`, all FSMs IDLE.
- Debounce, D=4, `IRQ_SOURCE_DEBOUNCE_EN` defined:
  - `btn[0]` high 3 cycles then low → no `irq`
  - `btn[0]` held high → `irq[0]` rises at edge 7.
- Handshake: `irq[1]` high, drive `running[1]=1` → `irq[1]` low next edge, `served_count=1`. Drive `running[1]=0` → IDLE.
- Queue on channel 2 during SERVE:
  - second press → `pending[2]=1`
  - third press → `dropped[2]=1`
  - `running[2]` falls → `irq[2]` high 2 edges later, `pending[2]=0`.
- All three channels pressed together, CPU asserts all `running` in one cycle → `served_count` 0→3. Preload to 0xFFFE → wraps to 0x0001.
- Macro undefined: single-cycle `btn[0]` pulse held past synchronizer → `irq[0]` at edge 3.
